// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - oversampled I2C target with 7-bit address match and byte-wide rx/tx handshake
module i2c_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_scl,
  input  logic       i2c_sda_in,
  output logic       i2c_sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, IGNORE, ADDR_ACK, RX, RX_ACK, TX, TX_ACK
  } state_t;

  // Synchronisers keep tracking the bus through reset so no false edge appears on release.
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_q, sda_q;

  always_ff @(posedge clk) begin
    scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl};
    sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda_in};
    scl_q    <= scl_sync[SYNC_STAGES-1];
    sda_q    <= sda_sync[SYNC_STAGES-1];
  end

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & ~sda_s & sda_q;
  assign stop_det  = scl_s & scl_q & sda_s & ~sda_q;

  state_t     state, state_n;
  logic [7:0] shift, shift_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic       rw, rw_n;
  logic       ack_phase, ack_phase_n;
  logic       sda_oe_n, busy_n, rx_valid_n, tx_req_n;
  logic [7:0] rx_data_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= 8'h00;
      bit_cnt    <= 3'd0;
      rw         <= 1'b0;
      ack_phase  <= 1'b0;
      i2c_sda_oe <= 1'b0;
      busy       <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      tx_req     <= 1'b0;
    end else begin
      state      <= state_n;
      shift      <= shift_n;
      bit_cnt    <= bit_cnt_n;
      rw         <= rw_n;
      ack_phase  <= ack_phase_n;
      i2c_sda_oe <= sda_oe_n;
      busy       <= busy_n;
      rx_data    <= rx_data_n;
      rx_valid   <= rx_valid_n;
      tx_req     <= tx_req_n;
    end
  end

  always_comb begin
    state_n     = state;
    shift_n     = shift;
    bit_cnt_n   = bit_cnt;
    rw_n        = rw;
    ack_phase_n = ack_phase;
    sda_oe_n    = i2c_sda_oe;
    busy_n      = busy;
    rx_data_n   = rx_data;
    rx_valid_n  = 1'b0;
    tx_req_n    = 1'b0;

    if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = 3'd0;
      shift_n   = 8'h00;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else if (stop_det) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else begin
      case (state)
        IDLE, IGNORE: ;
        ADDR: begin
          if (scl_rise) begin
            shift_n   = {shift[6:0], sda_s};
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (shift[6:0] == DEV_ADDR) begin
                rw_n        = sda_s;
                busy_n      = 1'b1;
                ack_phase_n = 1'b0;
                tx_req_n    = sda_s;
                state_n     = ADDR_ACK;
              end else begin
                state_n = IGNORE;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_phase) begin
              sda_oe_n    = 1'b1;
              ack_phase_n = 1'b1;
            end else if (!rw) begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = 3'd0;
              state_n   = RX;
            end else begin
              shift_n   = tx_data;
              sda_oe_n  = ~tx_data[7];
              bit_cnt_n = 3'd0;
              state_n   = TX;
            end
          end
        end
        RX: begin
          if (scl_rise) begin
            shift_n   = {shift[6:0], sda_s};
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data_n   = {shift[6:0], sda_s};
              rx_valid_n  = 1'b1;
              ack_phase_n = 1'b0;
              state_n     = RX_ACK;
            end
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            if (!ack_phase) begin
              sda_oe_n    = 1'b1;
              ack_phase_n = 1'b1;
            end else begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = 3'd0;
              state_n   = RX;
            end
          end
        end
        TX: begin
          // bit_cnt counts falls since bit 7 went out; the 8th fall ends bit 0.
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe_n    = 1'b0;
              ack_phase_n = 1'b0;
              state_n     = TX_ACK;
            end else begin
              shift_n   = {shift[6:0], 1'b0};
              sda_oe_n  = ~shift[6];
              bit_cnt_n = bit_cnt + 3'd1;
            end
          end
        end
        TX_ACK: begin
          if (scl_rise && !ack_phase) begin
            if (!sda_s) begin
              tx_req_n    = 1'b1;
              ack_phase_n = 1'b1;
            end else begin
              busy_n  = 1'b0;
              state_n = IGNORE;
            end
          end else if (scl_fall && ack_phase) begin
            shift_n   = tx_data;
            sda_oe_n  = ~tx_data[7];
            bit_cnt_n = 3'd0;
            state_n   = TX;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - scoreboard bench for i2c_target driven by a bit-level bus controller model
module tb_i2c_target;
  localparam int Q = 5;
  localparam logic [6:0] DEV = 7'h50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       ctrl_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       sda;
  logic       i2c_sda_oe, rx_valid, tx_req, busy;
  logic [7:0] rx_data;

  assign sda = ~(ctrl_low | i2c_sda_oe);

  i2c_target #(.DEV_ADDR(DEV), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .i2c_scl(scl), .i2c_sda_in(sda), .i2c_sda_oe(i2c_sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req), .busy(busy)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] tx_src[$];
  logic [7:0] last_rx = 8'h00;
  logic       oe_seen = 1'b0;
  int         od_viol = 0;
  logic       prev_scl = 1'b1;
  logic       prev_oe = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected write bytes on rx_valid, serves read bytes on tx_req.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        if (exp_rx.size() == 0) begin
          tests++; fails++;
          $display("FAIL rx_valid_unexpected: got rx_data %0h expected no pulse", rx_data);
        end else begin
          check("rx_data", int'(rx_data), int'(exp_rx.pop_front()));
        end
      end
      if (tx_req) begin
        tests++;
        if (tx_src.size() == 0) begin
          fails++;
          $display("FAIL tx_req_unexpected: got pulse expected none");
        end else begin
          tx_data = tx_src.pop_front();
        end
      end
    end
    if (i2c_sda_oe) oe_seen = 1'b1;
    if (scl && prev_scl && i2c_sda_oe && !prev_oe) od_viol++;
    prev_scl = scl;
    prev_oe  = i2c_sda_oe;
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    if (!scl) begin
      wclk(Q); ctrl_low = 1'b0; wclk(Q); scl = 1'b1; wclk(Q);
    end
    ctrl_low = 1'b1; wclk(Q); scl = 1'b0;
  endtask

  task automatic bus_stop();
    wclk(Q); ctrl_low = 1'b1; wclk(Q); scl = 1'b1; wclk(Q); ctrl_low = 1'b0; wclk(Q);
  endtask

  task automatic bus_bit(input logic b, output logic s);
    wclk(Q); ctrl_low = !b; wclk(Q); scl = 1'b1; wclk(Q); s = sda; wclk(Q); scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    bus_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    wclk(Q); ctrl_low = ack; wclk(Q); scl = 1'b1; wclk(Q);
    check("read_ack_slot_oe", int'(i2c_sda_oe), 0);
    wclk(Q); scl = 1'b0;
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] data[$]);
    logic match, ack;
    match = (a == DEV);
    oe_seen = 1'b0;
    bus_start();
    write_byte({a, 1'b0}, ack);
    check("addr_ack_w", int'(ack), match ? 0 : 1);
    check("busy_after_addr_w", int'(busy), int'(match));
    foreach (data[i]) begin
      if (match) begin
        exp_rx.push_back(data[i]);
        last_rx = data[i];
      end
      write_byte(data[i], ack);
      check("data_ack", int'(ack), match ? 0 : 1);
    end
    bus_stop();
    wclk(2);
    check("busy_after_stop_w", int'(busy), 0);
    check("rx_drained", exp_rx.size(), 0);
    if (!match) check("oe_silent_w", int'(oe_seen), 0);
  endtask

  task automatic do_read(input logic [6:0] a, input logic [7:0] data[$]);
    logic match, ack;
    logic [7:0] d;
    match = (a == DEV);
    oe_seen = 1'b0;
    if (match) foreach (data[i]) tx_src.push_back(data[i]);
    bus_start();
    write_byte({a, 1'b1}, ack);
    check("addr_ack_r", int'(ack), match ? 0 : 1);
    check("busy_after_addr_r", int'(busy), int'(match));
    foreach (data[i]) begin
      read_byte(i < data.size() - 1, d);
      check("read_data", int'(d), match ? int'(data[i]) : 8'hFF);
    end
    wclk(2);
    check("busy_after_nack", int'(busy), 0);
    bus_stop();
    check("tx_drained", tx_src.size(), 0);
    if (!match) check("oe_silent_r", int'(oe_seen), 0);
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] d;
    logic [7:0] q[$];
    logic [6:0] a;
    int         n;

    wclk(4);
    check("rst_oe", int'(i2c_sda_oe), 0);
    check("rst_rx_data", int'(rx_data), 0);
    check("rst_rx_valid", int'(rx_valid), 0);
    check("rst_tx_req", int'(tx_req), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    wclk(4);

    q = '{8'hA5};        do_write(7'h50, q);
    q = '{8'hFF};        do_write(7'h51, q);
    q = '{8'h3C};        do_read(7'h50, q);
    q = '{8'h3C, 8'hC3}; do_read(7'h50, q);

    // Write cut short by a repeated START, then a read of the same target.
    bus_start();
    write_byte({DEV, 1'b0}, ack);
    check("rs_addr_ack", int'(ack), 0);
    for (int i = 0; i < 4; i++) bus_bit(1'($urandom), s);
    tx_src.push_back(8'h5A);
    bus_start();
    write_byte({DEV, 1'b1}, ack);
    check("rs_addr2_ack", int'(ack), 0);
    read_byte(1'b0, d);
    check("rs_read_data", int'(d), 8'h5A);
    bus_stop();
    check("rs_rx_unchanged", int'(rx_data), int'(last_rx));
    check("rs_tx_drained", tx_src.size(), 0);

    // Reset while the target drives a low data bit.
    tx_src.push_back(8'h00);
    bus_start();
    write_byte({DEV, 1'b1}, ack);
    check("rr_addr_ack", int'(ack), 0);
    for (int i = 0; i < 4; i++) begin
      bus_bit(1'b1, s);
      check("rr_bit_hi", int'(s), 0);
    end
    wclk(Q);
    check("rr_oe_before", int'(i2c_sda_oe), 1);
    rst = 1'b1;
    wclk(1);
    check("rr_oe_after", int'(i2c_sda_oe), 0);
    check("rr_busy_after", int'(busy), 0);
    rst = 1'b0;
    oe_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_bit(1'b1, s);
      check("rr_bit_lo", int'(s), 1);
    end
    bus_stop();
    check("rr_oe_silent", int'(oe_seen), 0);
    q = '{8'h11}; do_write(7'h50, q);

    for (int t = 0; t < 8; t++) begin
      a = ($urandom_range(0, 2) != 0) ? DEV : 7'($urandom);
      n = $urandom_range(1, 3);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      if ($urandom_range(0, 1) == 1) do_read(a, q);
      else do_write(a, q);
    end

    check("open_drain", od_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
